rf_wr_arbiter: RTL and testbench
================================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, register data width.
REQ-002 The block SHALL have parameter AW, default 3, register address width; the register count is 2^AW.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port areset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port clr_req, input, 1, request to start a zeroing sweep of all registers.
REQ-006 The block SHALL have port clr_busy, output, 1, high while the sweep is in progress.
REQ-007 The block SHALL have ports a_valid (input, 1), a_ready (output, 1), a_waddr (input, AW) and a_wdata (input, DW), forming requester A's write channel.
REQ-008 The block SHALL have ports b_valid (input, 1), b_ready (output, 1), b_waddr (input, AW) and b_wdata (input, DW), forming requester B's write channel.
REQ-009 The block SHALL have ports rf_we (output, 1), rf_waddr (output, AW) and rf_wdata (output, DW), all registered, driving the register-file write port.
REQ-010 The block SHALL have port last_grant, output, 1, identifying the last requester granted (0=A, 1=B).

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-012 In IDLE with clr_req=0, the block SHALL derive the grant combinationally: only A valid -> A; only B valid -> B; both valid -> the requester that is not last_grant; neither valid -> none.
REQ-013 The block SHALL assert a_ready/b_ready only for the granted requester, and at most one ready SHALL be high in any cycle.
REQ-014 The block SHALL treat a transfer as valid&&ready at a rising edge; on a transfer, the next-cycle values SHALL be rf_we=1, rf_waddr=waddr and rf_wdata=wdata of the winner (latency 1 cycle).
REQ-015 In any cycle without a transfer or sweep write, the block SHALL drive rf_we=0 in the next cycle, with rf_waddr/rf_wdata holding their previous values.
REQ-016 The block SHALL update last_grant only on a transfer, to the winner's ID.
REQ-017 In IDLE, the block SHALL give clr_req=1 priority over both requesters: both readies are 0 in that cycle; at the edge, the FSM moves to CLEAR and sweep counter cnt=0.
REQ-018 In CLEAR, each edge SHALL register rf_we=1, rf_waddr=cnt and rf_wdata=0, then increment cnt; the edge with cnt=2^AW-1 SHALL return the FSM to IDLE, giving exactly 2^AW consecutive writes to addresses 0..2^AW-1 in ascending order.
REQ-019 In CLEAR, the block SHALL hold a_ready=b_ready=0 and ignore clr_req; pending valids SHALL be served after the return to IDLE, using normal arbitration.
REQ-020 The block SHALL drive clr_busy=1 exactly while the FSM is in CLEAR.
REQ-021 The block SHALL leave cnt unchanged in IDLE, and cnt SHALL wrap only through the return to IDLE.
REQ-022 The block SHALL require valid, waddr and wdata to stay stable while ready is low; the block SHALL not buffer un-accepted requests.

Reset
REQ-023 While areset_n=0, the block SHALL force the following immediately, regardless of clk: FSM=IDLE, cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, last_grant=1, clr_busy=0, a_ready=b_ready=0.
REQ-024 An assertion of areset_n mid-sweep SHALL abort the sweep with no further rf_we pulses; after release, the first tie SHALL go to A.
REQ-025 The block SHALL sample no inputs and raise no ready until the first rising edge after areset_n rises.

Verification
REQ-026 The bench SHALL cover reset release followed by a_valid=b_valid=1 for 4 cycles (A: addr 1/data 0x11; B: addr 2/data 0x22) -> grants A,B,A,B, and rf_we pulses carry (1,0x11),(2,0x22),(1,0x11),(2,0x22) one cycle after each grant.
REQ-027 The bench SHALL cover only b_valid=1 (addr 5, data 0xA5) for 1 cycle -> b_ready=1, a_ready=0; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xA5; last_grant=1.
REQ-028 The bench SHALL cover a 1-cycle clr_req pulse with a_valid=1 -> a_ready=0 for 9 cycles, rf_we=1 for 8 cycles with addresses 0..7 and data 0, clr_busy=1 for 8 cycles; then A is granted.
REQ-029 The bench SHALL cover clr_req held high throughout a sweep -> exactly 8 sweep writes, then a second sweep starts immediately after the return to IDLE.
REQ-030 The bench SHALL cover areset_n driven low mid-clk-cycle after the 3rd sweep write -> rf_we and clr_busy drop to 0 without waiting for an edge; no write to address 3 occurs; the next tie grants A.
REQ-031 The bench SHALL cover the idle case, no valids and no clr_req for 10 cycles -> rf_we stays 0 and last_grant is unchanged.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two-requester write arbiter for a small register file with a
// built-in zeroing sweep. Ties alternate between A and B. A sweep writes zero to
// every register in ascending address order. Requesters are locked out while
// the sweep runs.
//
// Handshake: a requester holds valid, waddr and wdata stable until it sees
// ready. A transfer happens at a rising edge where valid && ready. Ready is
// combinational from valid, the FSM state and last_grant. Requests that are not
// accepted are never buffered here.
module rf_wr_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_waddr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_waddr,
    input  logic [DW-1:0] b_wdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          last_grant,
    output logic [0:0]    o_dbg_state
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_started;
    logic          r_rf_we;
    logic [AW-1:0] r_rf_waddr;
    logic [DW-1:0] r_rf_wdata;
    logic          r_last_grant;

    logic w_idle;
    logic w_arb_en;
    logic w_clr_start;
    logic w_gnt_a;
    logic w_gnt_b;

    // Nothing is sampled and no ready rises before the first edge after reset
    // release. r_started marks that this edge has occurred.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    assign w_idle      = r_started && (r_state == ST_IDLE);
    assign w_clr_start = w_idle && clr_req;
    assign w_arb_en    = w_idle && !clr_req;

    // On a tie, grant the requester that was not granted last time.
    assign w_gnt_a = w_arb_en && a_valid && (!b_valid || r_last_grant);
    assign w_gnt_b = w_arb_en && b_valid && (!a_valid || !r_last_grant);

    // FSM and sweep counter. The counter wraps to zero on the final sweep edge,
    // which is the same edge that returns the FSM to IDLE.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_clr_start) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Registered write port and last_grant. The write enable pulses for one
    // cycle per transfer or sweep step. Address and data hold their values
    // otherwise.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_rf_we <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= r_cnt;
                r_rf_wdata <= '0;
            end else if (w_gnt_a) begin
                r_rf_we      <= 1'b1;
                r_rf_waddr   <= a_waddr;
                r_rf_wdata   <= a_wdata;
                r_last_grant <= 1'b0;
            end else if (w_gnt_b) begin
                r_rf_we      <= 1'b1;
                r_rf_waddr   <= b_waddr;
                r_rf_wdata   <= b_wdata;
                r_last_grant <= 1'b1;
            end
        end
    end

    assign a_ready     = w_gnt_a;
    assign b_ready     = w_gnt_b;
    assign clr_busy    = (r_state == ST_CLEAR);
    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign last_grant  = r_last_grant;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter. The directed driver pushes the expected register-file
// writes as {addr, data} into exp_q. A negedge monitor pops and compares every
// rf_we pulse it sees.
module tb_rf_wr_arbiter;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          areset_n;
  logic          clr_req;
  logic          clr_busy;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_waddr;
  logic [DW-1:0] a_wdata;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_waddr;
  logic [DW-1:0] b_wdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          last_grant;
  logic [0:0]    dbg_state;

  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  rf_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .areset_n(areset_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .last_grant(last_grant), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic push_sweep(input int n);
    for (int k = 0; k < n; k++) push_wr(AW'(k), '0);
  endtask

  // monitor: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (a_ready === 1'b1 && b_ready === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL both_ready: act=11 exp=one_hot");
    end
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: act=addr %0h data %0h exp=none", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL write: act=addr %0h data %0h exp=addr %0h data %0h",
                   rf_waddr, rf_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver
  initial begin
    areset_n = 1'b0;
    clr_req  = 1'b0;
    a_valid  = 1'b0; a_waddr = '0; a_wdata = '0;
    b_valid  = 1'b0; b_waddr = '0; b_wdata = '0;
    #12;
    chk("rst_rf_we",      32'(rf_we),      0);
    chk("rst_rf_waddr",   32'(rf_waddr),   0);
    chk("rst_rf_wdata",   32'(rf_wdata),   0);
    chk("rst_last_grant", 32'(last_grant), 1);
    chk("rst_clr_busy",   32'(clr_busy),   0);
    chk("rst_readies",    32'({a_ready, b_ready}), 0);
    tick();
    tick();

    // Release with a tie already present. No ready may rise before the first edge.
    areset_n = 1'b1;
    a_valid = 1'b1; a_waddr = 3'd1; a_wdata = 8'h11;
    b_valid = 1'b1; b_waddr = 3'd2; b_wdata = 8'h22;
    @(negedge clk);
    chk("first_cycle_readies", 32'({a_ready, b_ready}), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i % 2 == 0) begin
        chk("tie_grant_a", 32'({a_ready, b_ready}), 32'b10);
        push_wr(3'd1, 8'h11);
      end else begin
        chk("tie_grant_b", 32'({a_ready, b_ready}), 32'b01);
        push_wr(3'd2, 8'h22);
      end
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;

    // only B valid
    b_valid = 1'b1; b_waddr = 3'd5; b_wdata = 8'hA5;
    @(negedge clk);
    chk("only_b_ready", 32'({a_ready, b_ready}), 32'b01);
    push_wr(3'd5, 8'hA5);
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    chk("only_b_last_grant", 32'(last_grant), 1);
    chk("only_b_rf_we", 32'(rf_we), 1);
    tick();

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rf_we", 32'(rf_we), 0);
      chk("idle_last_grant", 32'(last_grant), 1);
      tick();
    end

    // one-cycle clr_req pulse while A waits
    clr_req = 1'b1;
    a_valid = 1'b1; a_waddr = 3'd4; a_wdata = 8'h44;
    @(negedge clk);
    chk("clr_req_a_ready", 32'(a_ready), 0);
    chk("clr_req_busy", 32'(clr_busy), 0);
    push_sweep(8);
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("sweep_a_ready", 32'(a_ready), 0);
      chk("sweep_busy", 32'(clr_busy), 1);
      tick();
    end
    @(negedge clk);
    chk("post_sweep_busy", 32'(clr_busy), 0);
    chk("post_sweep_grant_a", 32'({a_ready, b_ready}), 32'b10);
    push_wr(3'd4, 8'h44);
    tick();
    a_valid = 1'b0;

    // clr_req held high: one full sweep, then a second one starts at once
    clr_req = 1'b1;
    @(negedge clk);
    chk("held_idle_busy", 32'(clr_busy), 0);
    chk("held_last_grant", 32'(last_grant), 0);
    push_sweep(8);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("held_sweep_busy", 32'(clr_busy), 1);
      tick();
    end
    @(negedge clk);
    chk("held_return_busy", 32'(clr_busy), 0);
    tick();
    clr_req = 1'b0;
    push_sweep(3);
    @(negedge clk);
    chk("second_sweep_first_we", 32'(rf_we), 0);
    for (int i = 0; i < 3; i++) begin
      chk("second_sweep_busy", 32'(clr_busy), 1);
      tick();
      @(negedge clk);
    end

    // The third sweep write is on the bus now. Reset mid-cycle.
    #1;
    chk("pre_reset_rf_we", 32'(rf_we), 1);
    chk("pre_reset_waddr", 32'(rf_waddr), 2);
    areset_n = 1'b0;
    #1;
    chk("async_rst_rf_we", 32'(rf_we), 0);
    chk("async_rst_busy", 32'(clr_busy), 0);
    chk("async_rst_waddr", 32'(rf_waddr), 0);
    chk("async_rst_last_grant", 32'(last_grant), 1);
    repeat (3) @(posedge clk);
    #1;
    areset_n = 1'b1;
    a_valid = 1'b1; a_waddr = 3'd6; a_wdata = 8'h66;
    b_valid = 1'b1; b_waddr = 3'd3; b_wdata = 8'h33;
    @(negedge clk);
    chk("rerelease_readies", 32'({a_ready, b_ready}), 0);
    tick();
    @(negedge clk);
    chk("rerelease_tie_a", 32'({a_ready, b_ready}), 32'b10);
    push_wr(3'd6, 8'h66);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    chk("rerelease_last_grant", 32'(last_grant), 0);
    repeat (3) tick();

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
